// File: rtl/gpi.sv
// Memory-mapped general-purpose input port: synchronised pins, sticky W1C edge captures, level irq.
// Optional per-pin debounce filter is compiled in with `define GPI_DEBOUNCE_EN.
module gpi #(
    parameter int          N         = 32,
    parameter logic [31:0] BASE      = 32'h1000_1000,
    parameter int          DB_CYCLES = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [N-1:0]  gpi_pin,
    output logic          irq,
    input  logic          i_rd,
    input  logic [31:0]   i_addr,
    input  logic          i_wr,
    input  logic [3:0]    i_wrmask,
    input  logic [31:0]   i_data,
    output logic          o_rd_valid,
    output logic          o_wr_valid,
    output logic [31:0]   o_data
);

    logic [N-1:0] sync1, sync2, filt, prev;
    logic [N-1:0] rise, fall, irq_en;
    logic [N-1:0] rise_set, fall_set, rise_clr, fall_clr;
    logic [N-1:0] wmask, wdata;
    logic [31:0]  byte_mask;
    logic [31:0]  rd_word;
    logic [1:0]   sel;
    logic         hit, rd_hit, wr_hit;
    logic         addr_unused;

    // BASE is 16-byte aligned, so the block hit is a compare of the upper address bits.
    assign hit         = (i_addr[31:4] == BASE[31:4]);
    assign sel         = i_addr[3:2];
    assign addr_unused = ^i_addr[1:0];
    assign rd_hit      = i_rd && hit;
    assign wr_hit      = i_wr && hit;

    assign byte_mask = {{8{i_wrmask[3]}}, {8{i_wrmask[2]}}, {8{i_wrmask[1]}}, {8{i_wrmask[0]}}};
    assign wmask     = byte_mask[N-1:0];
    assign wdata     = i_data[N-1:0];

    assign rise_set = filt & ~prev;
    assign fall_set = ~filt & prev;
    assign rise_clr = (wr_hit && sel == 2'd1) ? (wdata & wmask) : '0;
    assign fall_clr = (wr_hit && sel == 2'd2) ? (wdata & wmask) : '0;

    assign irq = |((rise | fall) & irq_en);

    always_comb begin
        rd_word = '0;
        case (sel)
            2'd0:    rd_word[N-1:0] = filt;
            2'd1:    rd_word[N-1:0] = rise;
            2'd2:    rd_word[N-1:0] = fall;
            default: rd_word[N-1:0] = irq_en;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= gpi_pin;
            sync2 <= sync1;
        end
    end

`ifdef GPI_DEBOUNCE_EN
    localparam int CW = (DB_CYCLES > 2) ? $clog2(DB_CYCLES) : 1;
    logic [CW-1:0] cnt [N];

    // filt follows sync2 only after sync2 has disagreed for DB_CYCLES consecutive edges.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            filt <= '0;
            for (int b = 0; b < N; b++) cnt[b] <= '0;
        end else begin
            for (int b = 0; b < N; b++) begin
                if (sync2[b] == filt[b]) begin
                    cnt[b] <= '0;
                end else if (cnt[b] == CW'(DB_CYCLES - 1)) begin
                    filt[b] <= sync2[b];
                    cnt[b]  <= '0;
                end else begin
                    cnt[b] <= cnt[b] + 1'b1;
                end
            end
        end
    end
`else
    always_ff @(posedge clk or posedge rst) begin
        if (rst) filt <= '0;
        else     filt <= sync2;
    end
`endif

    // Set wins over a same-cycle W1C clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev   <= '0;
            rise   <= '0;
            fall   <= '0;
            irq_en <= '0;
        end else begin
            prev <= filt;
            rise <= (rise & ~rise_clr) | rise_set;
            fall <= (fall & ~fall_clr) | fall_set;
            if (wr_hit && sel == 2'd3)
                irq_en <= (irq_en & ~wmask) | (wdata & wmask);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            o_rd_valid <= 1'b0;
            o_wr_valid <= 1'b0;
            o_data     <= '0;
        end else begin
            o_rd_valid <= rd_hit;
            o_wr_valid <= wr_hit;
            o_data     <= rd_hit ? rd_word : 32'h0;
        end
    end

endmodule

// File: tb/tb_gpi.sv
// Self-checking bench for gpi: directed steps plus random traffic against a pin-history reference model.
// Build with GPI_DEBOUNCE_EN defined to cover the debounce filter.
module tb_gpi;

    localparam logic [31:0] BASE = 32'h1000_1000;
`ifdef GPI_DEBOUNCE_EN
    localparam int W = 16;
`else
    localparam int W = 1;
`endif
    localparam int SETTLE = W + 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] gpi_pin = '0;
    logic        irq;
    logic        i_rd = 1'b0;
    logic [31:0] i_addr = '0;
    logic        i_wr = 1'b0;
    logic [3:0]  i_wrmask = '0;
    logic [31:0] i_data = '0;
    logic        o_rd_valid, o_wr_valid;
    logic [31:0] o_data;

    int n_assert = 0;
    int n_fail   = 0;

    gpi #(.N(32), .BASE(BASE), .DB_CYCLES(16)) dut (
        .clk(clk), .rst(rst), .gpi_pin(gpi_pin), .irq(irq),
        .i_rd(i_rd), .i_addr(i_addr), .i_wr(i_wr), .i_wrmask(i_wrmask), .i_data(i_data),
        .o_rd_valid(o_rd_valid), .o_wr_valid(o_wr_valid), .o_data(o_data)
    );

    always #5 clk = ~clk;

    // Reference model: hist[j] holds the pin value sampled j+1 edges ago.
    logic [31:0] hist [64];
    logic [31:0] m_filt, m_prev, m_rise, m_fall, m_en;
    logic        exp_rv, exp_wv, exp_irq;
    logic [31:0] exp_data;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int j = 0; j < 64; j++) hist[j] = '0;
        m_filt = '0; m_prev = '0; m_rise = '0; m_fall = '0; m_en = '0;
        exp_rv = 0; exp_wv = 0; exp_irq = 0; exp_data = '0;
    endtask

    task automatic model_edge(input bit rd, input bit wr, input logic [31:0] addr,
                              input logic [3:0] m, input logic [31:0] d);
        logic [63:0] a;
        bit          hit, flip;
        int          idx;
        logic [31:0] regv, bm, clr, nf, nr, nfa;
        a   = {32'h0, addr};
        hit = (a >= {32'h0, BASE}) && (a < {32'h0, BASE} + 64'd16);
        idx = int'(addr[3:2]);
        case (idx)
            0: regv = m_filt;
            1: regv = m_rise;
            2: regv = m_fall;
            default: regv = m_en;
        endcase
        exp_rv   = rd && hit;
        exp_wv   = wr && hit;
        exp_data = exp_rv ? regv : 32'h0;
        for (int k = 0; k < 4; k++) bm[k*8 +: 8] = {8{m[k]}};
        clr = (wr && hit) ? (d & bm) : 32'h0;
        nr  = (m_rise & ~((idx == 1) ? clr : 32'h0)) | (m_filt & ~m_prev);
        nfa = (m_fall & ~((idx == 2) ? clr : 32'h0)) | (~m_filt & m_prev);
        if (wr && hit && idx == 3) m_en = (m_en & ~bm) | (d & bm);
        // A filtered bit flips once the synchronised pin has disagreed with it for W edges in a row.
        for (int b = 0; b < 32; b++) begin
            flip = 1;
            for (int j = 1; j <= W; j++)
                if (hist[j][b] == m_filt[b]) flip = 0;
            nf[b] = flip ? ~m_filt[b] : m_filt[b];
        end
        m_prev = m_filt;
        m_filt = nf;
        m_rise = nr;
        m_fall = nfa;
        for (int j = 63; j > 0; j--) hist[j] = hist[j-1];
        hist[0] = gpi_pin;
        exp_irq = |((m_rise | m_fall) & m_en);
    endtask

    // One clock: drive at negedge, check #1 after posedge, return at next negedge.
    task automatic step(input bit rd, input bit wr, input logic [31:0] addr,
                        input logic [3:0] m, input logic [31:0] d);
        i_rd = rd; i_wr = wr; i_addr = addr; i_wrmask = m; i_data = d;
        model_edge(rd, wr, addr, m, d);
        @(posedge clk); #1;
        i_rd = 0; i_wr = 0;
        chk("rd_valid", {31'h0, o_rd_valid}, {31'h0, exp_rv});
        chk("rd_data",  o_data, exp_data);
        chk("wr_valid", {31'h0, o_wr_valid}, {31'h0, exp_wv});
        chk("irq",      {31'h0, irq}, {31'h0, exp_irq});
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 32'h0, 4'h0, 32'h0);
    endtask

    task automatic rd(input logic [31:0] addr);
        step(1, 0, addr, 4'h0, 32'h0);
    endtask

    task automatic wr(input logic [31:0] addr, input logic [3:0] m, input logic [31:0] d);
        step(0, 1, addr, m, d);
    endtask

    initial begin
        logic [31:0] addr;
        int          hold;
        model_reset();
        repeat (3) @(negedge clk);
        rst = 0;

        // Reset state
        chk("reset_irq", {31'h0, irq}, 32'h0);
        for (int k = 0; k < 4; k++) begin
            rd(BASE + 32'(k * 4));
            chk("reset_read", o_data, 32'h0);
        end

        // Pins 0xA5 propagate to DATA and RISE
        gpi_pin = 32'h0000_00A5;
        idle(SETTLE);
        rd(BASE);       chk("data_a5", o_data, 32'h0000_00A5);
        rd(BASE + 4);   chk("rise_a5", o_data, 32'h0000_00A5);
        rd(BASE + 8);   chk("fall_0",  o_data, 32'h0);

        // irq enable and W1C clear
        wr(BASE + 12, 4'hF, 32'h1);
        chk("irq_on", {31'h0, irq}, 32'h1);
        wr(BASE + 4, 4'hF, 32'h1);
        chk("irq_off", {31'h0, irq}, 32'h0);
        rd(BASE + 4);   chk("rise_a4", o_data, 32'h0000_00A4);

        // Byte-masked W1C: lane 0 disabled leaves RISE intact
        wr(BASE + 4, 4'hE, 32'hFFFF_FFFF);
        rd(BASE + 4);   chk("rise_mask", o_data, 32'h0000_00A4);

        // Falling edge on pin0, then clear it
        gpi_pin = 32'h0000_00A4;
        idle(SETTLE);
        chk("irq_fall", {31'h0, irq}, 32'h1);
        wr(BASE + 8, 4'hF, 32'h1);
        chk("irq_fall_clr", {31'h0, irq}, 32'h0);

        // New rising edge on pin0 lands on the same edge as a W1C of RISE bit0: set wins
        gpi_pin = 32'h0000_00A5;
        idle(W + 2);
        wr(BASE + 4, 4'hF, 32'h1);
        chk("set_wins_irq", {31'h0, irq}, 32'h1);
        rd(BASE + 4);   chk("set_wins_rise", o_data, 32'h0000_00A5);

        // Misses: no response, no state change
        rd(BASE + 16);            chk("miss_rd_hi", o_data, 32'h0);
        rd(BASE - 4);             chk("miss_rd_lo", o_data, 32'h0);
        wr(BASE - 4, 4'hF, 32'hFFFF_FFFF);
        wr(BASE + 16, 4'hF, 32'hFFFF_FFFF);
        rd(BASE + 12);            chk("miss_en", o_data, 32'h1);

        // Simultaneous read and write to IRQ_EN returns pre-write value
        step(1, 1, BASE + 12, 4'h3, 32'h0000_F0F0);
        chk("rdwr_pre", o_data, 32'h1);
        rd(BASE + 12);            chk("rdwr_post", o_data, 32'h0000_F0F0);

`ifdef GPI_DEBOUNCE_EN
        gpi_pin = '0;
        idle(SETTLE + 4);
        wr(BASE + 4, 4'hF, 32'hFFFF_FFFF);
        wr(BASE + 8, 4'hF, 32'hFFFF_FFFF);
        gpi_pin = 32'h8;
        idle(10);
        gpi_pin = '0;
        idle(30);
        rd(BASE);       chk("db_short_data", o_data, 32'h0);
        rd(BASE + 4);   chk("db_short_rise", o_data, 32'h0);
        gpi_pin = 32'h8;
        idle(20);
        rd(BASE + 4);   chk("db_long_rise", o_data & 32'h8, 32'h8);
        gpi_pin = '0;
        idle(30);
        rd(BASE + 8);   chk("db_long_fall", o_data & 32'h8, 32'h8);
`endif

        // Random traffic
        hold = 0;
        for (int i = 0; i < 600; i++) begin
            if (hold == 0) begin
                gpi_pin = $urandom;
                hold = int'($urandom_range(1, 3 * W + 6));
            end
            hold--;
            case ($urandom_range(0, 5))
                0:       addr = BASE + 16;
                1:       addr = BASE - 4;
                2:       addr = $urandom;
                default: addr = BASE + {28'h0, 4'($urandom_range(0, 15))};
            endcase
            step(bit'($urandom_range(0, 1)), bit'($urandom_range(0, 2) == 0), addr,
                 4'($urandom), $urandom);
        end

        // Reset during a pending read
        i_rd = 1; i_addr = BASE + 4;
        @(posedge clk); #1;
        i_rd = 0;
        rst = 1;
        #1;
        chk("rst_rv",   {31'h0, o_rd_valid}, 32'h0);
        chk("rst_data", o_data, 32'h0);
        chk("rst_irq",  {31'h0, irq}, 32'h0);
        gpi_pin = '0;
        model_reset();
        @(negedge clk); @(negedge clk);
        rst = 0;
        for (int k = 0; k < 4; k++) begin
            rd(BASE + 32'(k * 4));
            chk("post_rst_read", o_data, 32'h0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
